// File: rtl/fft_r2_dif_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 DIF FFT.
// Twiddles are (cos, sin) pairs in Q1.14; callers apply W = c - j*s.
package fft_r2_dif_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  localparam int TW_FRAC  = 14;
  localparam int TW_WIDTH = 16;

  typedef struct packed {
    logic signed [TW_WIDTH-1:0] c;
    logic signed [TW_WIDTH-1:0] s;
  } tw_t;

  function automatic tw_t twiddle(input int m, input int pow);
    real ang, cr, sr;
    tw_t t;
    ang = 2.0 * 3.14159265358979323846 * real'(m) / real'(1 << pow);
    cr  = $cos(ang) * real'(1 << TW_FRAC);
    sr  = $sin(ang) * real'(1 << TW_FRAC);
    t.c = TW_WIDTH'($rtoi(cr >= 0.0 ? cr + 0.5 : cr - 0.5));
    t.s = TW_WIDTH'($rtoi(sr >= 0.0 ? sr + 0.5 : sr - 0.5));
    return t;
  endfunction

  function automatic int bitrev(input int k, input int pow);
    int r;
    r = 0;
    for (int i = 0; i < pow; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

endpackage

// File: rtl/fft_r2_dif_if.sv
// Sample-in / spectrum-out stream bundle for fft_r2_dif.
interface fft_r2_dif_if #(
  parameter int DATA_WIDTH = 11,
  parameter int POW        = 3
);
  localparam int W = DATA_WIDTH + 2 * POW;

  logic                         en;
  logic signed [DATA_WIDTH-1:0] sink_r;
  logic signed [DATA_WIDTH-1:0] sink_i;
  logic signed [W-1:0]          source_r;
  logic signed [W-1:0]          source_i;
  logic                         valid;

  modport master (output en, sink_r, sink_i, input source_r, source_i, valid);
  modport slave  (input en, sink_r, sink_i, output source_r, source_i, valid);
endinterface

// File: rtl/fft_r2_butterfly.sv
// Combinational DIF butterfly: x = a + b, y = (a - b) * (c - j*s), rounded Q14.
module fft_r2_butterfly
  import fft_r2_dif_pkg::*;
#(
  parameter int W = 17
) (
  input  logic signed [W-1:0] a_r,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_r,
  input  logic signed [W-1:0] b_i,
  input  tw_t                 tw,
  output logic signed [W-1:0] x_r,
  output logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_r,
  output logic signed [W-1:0] y_i
);
  localparam int PW = W + TW_WIDTH + 2;
  localparam logic signed [PW-1:0] RND = PW'(1 << (TW_FRAC - 1));

  logic signed [W:0]    d_r, d_i;
  logic signed [PW-1:0] p_r, p_i;

  assign x_r = a_r + b_r;
  assign x_i = a_i + b_i;

  // keep one guard bit on the difference so the product sees the true value
  assign d_r = (W+1)'(a_r) - (W+1)'(b_r);
  assign d_i = (W+1)'(a_i) - (W+1)'(b_i);

  assign p_r = PW'(d_r) * PW'($signed(tw.c)) + PW'(d_i) * PW'($signed(tw.s)) + RND;
  assign p_i = PW'(d_i) * PW'($signed(tw.c)) - PW'(d_r) * PW'($signed(tw.s)) + RND;

  assign y_r = W'(p_r >>> TW_FRAC);
  assign y_i = W'(p_i >>> TW_FRAC);
endmodule

// File: rtl/fft_r2_dif.sv
// In-place radix-2 DIF FFT: load N samples, run POW*N/2 butterflies, stream bit-reversed read-out.
//   state   | meaning
//   LOAD    | capture one sample per en into mem[cnt]
//   COMPUTE | one butterfly per cycle, stage-major, then group, then offset
//   OUTPUT  | present mem[bitrev(cnt)] with valid, N cycles
module fft_r2_dif
  import fft_r2_dif_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int POW        = 3
) (
  input  logic         clk,
  input  logic         rst,
  fft_r2_dif_if.slave  bus
);
  localparam int N  = 1 << POW;
  localparam int W  = DATA_WIDTH + 2 * POW;
  localparam int SW = $clog2(POW);

  state_t              state;
  logic [POW-1:0]      cnt;
  logic [SW-1:0]       stage;
  logic [POW-2:0]      bf;
  logic [POW-1:0]      addr_a, addr_b, rd_addr;
  logic [POW-2:0]      tw_idx;
  logic signed [W-1:0] mem_r [N];
  logic signed [W-1:0] mem_i [N];
  tw_t                 tw_rom [N/2];
  logic signed [W-1:0] x_r, x_i, y_r, y_i;

  for (genvar g = 0; g < N/2; g++) begin : g_tw
    localparam tw_t TW = twiddle(g, POW);
    assign tw_rom[g] = TW;
  end

  // bf counts butterflies within a stage; split it into group and offset j
  always_comb begin
    int s, h, j, grp;
    s      = int'(stage);
    h      = N >> (s + 1);
    j      = int'(bf) & (h - 1);
    grp    = int'(bf) >> (POW - 1 - s);
    addr_a = POW'((grp << (POW - s)) + j);
    addr_b = POW'((grp << (POW - s)) + j + h);
    tw_idx = (POW-1)'(j << s);
  end

  assign rd_addr = POW'(bitrev(int'(cnt), POW));

  fft_r2_butterfly #(.W(W)) u_bfly (
    .a_r (mem_r[addr_a]),
    .a_i (mem_i[addr_a]),
    .b_r (mem_r[addr_b]),
    .b_i (mem_i[addr_b]),
    .tw  (tw_rom[tw_idx]),
    .x_r (x_r),
    .x_i (x_i),
    .y_r (y_r),
    .y_i (y_i)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      cnt          <= '0;
      stage        <= '0;
      bf           <= '0;
      bus.valid    <= 1'b0;
      bus.source_r <= '0;
      bus.source_i <= '0;
      for (int k = 0; k < N; k++) begin
        mem_r[k] <= '0;
        mem_i[k] <= '0;
      end
    end else begin
      bus.valid    <= 1'b0;
      bus.source_r <= '0;
      bus.source_i <= '0;
      unique case (state)
        LOAD: begin
          if (bus.en) begin
            mem_r[cnt] <= W'(bus.sink_r) <<< POW;
            mem_i[cnt] <= W'(bus.sink_i) <<< POW;
            cnt        <= cnt + 1'b1;
            if (cnt == POW'(N - 1)) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          mem_r[addr_a] <= x_r;
          mem_i[addr_a] <= x_i;
          mem_r[addr_b] <= y_r;
          mem_i[addr_b] <= y_i;
          bf            <= bf + 1'b1;
          if (bf == (POW-1)'(N/2 - 1)) begin
            if (stage == SW'(POW - 1)) begin
              stage <= '0;
              cnt   <= '0;
              state <= OUTPUT;
            end else begin
              stage <= stage + 1'b1;
            end
          end
        end
        OUTPUT: begin
          bus.valid    <= 1'b1;
          bus.source_r <= mem_r[rd_addr];
          bus.source_i <= mem_i[rd_addr];
          cnt          <= cnt + 1'b1;
          if (cnt == POW'(N - 1)) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_r2_dif.sv
// Self-checking bench for fft_r2_dif: floating-point DFT reference plus literal spot values.
module tb_fft_r2_dif;
  localparam int DW  = 11;
  localparam int POW = 3;
  localparam int N   = 8;
  localparam int LAT = 13;
  localparam int TOL = 2;
  localparam real PI = 3.14159265358979323846;

  typedef struct { int r; int i; } cplx_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   run_len = 0;

  cplx_t exp_q[$];
  int    cap_q[$];
  int    fr[N], fi[N];
  int    got_r[N], got_i[N];
  int    mdl_r[N], mdl_i[N];
  int    lit_r[N], lit_i[N];
  int    sav_r[N], sav_i[N];

  fft_r2_dif_if #(.DATA_WIDTH(DW), .POW(POW)) bus ();

  fft_r2_dif #(.DATA_WIDTH(DW), .POW(POW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req, input int tol);
    vectors++;
    if (act > req + tol || act < req - tol) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, req, tol);
    end
  endtask

  function automatic int rnd(input real v);
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  // reference: direct DFT of the current frame, times 2^POW
  task automatic model_frame();
    for (int k = 0; k < N; k++) begin
      real sr, si, a;
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        a  = 2.0 * PI * real'(k * n) / real'(N);
        sr = sr + real'(fr[n]) * $cos(a) + real'(fi[n]) * $sin(a);
        si = si + real'(fi[n]) * $cos(a) - real'(fr[n]) * $sin(a);
      end
      mdl_r[k] = rnd(sr * real'(N));
      mdl_i[k] = rnd(si * real'(N));
      exp_q.push_back('{mdl_r[k], mdl_i[k]});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (bus.valid) begin
      cplx_t e;
      if (run_len == 0) begin
        chk("latency_frame_known", int'(cap_q.size() > 0), 1, 0);
        if (cap_q.size() > 0) chk("latency", cyc - cap_q.pop_front(), LAT, 0);
      end
      chk("output_expected", int'(exp_q.size() > 0), 1, 0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("X%0d_re", run_len), int'(bus.source_r), e.r, TOL);
        chk($sformatf("X%0d_im", run_len), int'(bus.source_i), e.i, TOL);
      end
      got_r[run_len % N] = int'(bus.source_r);
      got_i[run_len % N] = int'(bus.source_i);
      run_len++;
    end else begin
      if (run_len != 0) begin
        chk("valid_len", run_len, N, 0);
        run_len = 0;
      end
      chk("idle_src_re", int'(bus.source_r), 0, 0);
      chk("idle_src_im", int'(bus.source_i), 0, 0);
    end
  end

  task automatic send_frame(input int gap);
    for (int n = 0; n < N; n++) begin
      for (int g = 0; g < gap * (n % 3); g++) begin
        @(negedge clk);
        bus.en     = 1'b0;
        bus.sink_r = DW'($urandom_range(0, 2047));
        bus.sink_i = DW'($urandom_range(0, 2047));
      end
      @(negedge clk);
      bus.en     = 1'b1;
      bus.sink_r = DW'(fr[n]);
      bus.sink_i = DW'(fi[n]);
    end
    @(negedge clk);
    bus.en = 1'b0;
    cap_q.push_back(cyc);
    model_frame();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("drain_budget", int'(k >= 100), 0, 0);
  endtask

  task automatic chk_lit(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_X%0d_re", tag, k), got_r[k], lit_r[k], 0);
      chk($sformatf("%s_X%0d_im", tag, k), got_i[k], lit_i[k], 0);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_valid"}, int'(bus.valid), 0, 0);
    chk({tag, "_src_re"}, int'(bus.source_r), 0, 0);
    chk({tag, "_src_im"}, int'(bus.source_i), 0, 0);
    exp_q.delete();
    cap_q.delete();
    run_len = 0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  function automatic int sv_r(input int t);
    return ((t * 37) % 200) - 100;
  endfunction

  function automatic int sv_i(input int t);
    return ((t * 11) % 60) - 30;
  endfunction

  initial begin
    rst = 1'b0;
    bus.en = 1'b0;
    bus.sink_r = '0;
    bus.sink_i = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(bus.valid), 0, 0);
    chk("reset_src_re", int'(bus.source_r), 0, 0);
    chk("reset_src_im", int'(bus.source_i), 0, 0);
    rst = 1'b0;

    // impulse
    fr = '{100, 0, 0, 0, 0, 0, 0, 0};
    fi = '{default: 0};
    send_frame(0);
    wait_done();
    lit_r = '{default: 800};
    lit_i = '{default: 0};
    chk_lit("impulse");

    // DC
    fr = '{default: 12};
    send_frame(0);
    wait_done();
    lit_r = '{768, 0, 0, 0, 0, 0, 0, 0};
    chk_lit("dc");

    // alternating
    for (int n = 0; n < N; n++) fr[n] = (n % 2 == 0) ? 50 : -50;
    send_frame(0);
    wait_done();
    lit_r = '{0, 0, 0, 0, 3200, 0, 0, 0};
    chk_lit("alt");

    // mixed real, gapless then gapped
    fr = '{12, 49, 2, 48, 70, 13, 5, 6};
    send_frame(0);
    chk("model_mix1_X0", mdl_r[0], 1640, 0);
    chk("model_mix1_X4", mdl_r[4], -216, 0);
    wait_done();
    chk("mix1_X0_re", got_r[0], 1640, 0);
    chk("mix1_X0_im", got_i[0], 0, 0);
    chk("mix1_X4_re", got_r[4], -216, 0);
    chk("mix1_X4_im", got_i[4], 0, 0);
    sav_r = got_r;
    sav_i = got_i;
    send_frame(1);
    wait_done();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("gap_X%0d_re", k), got_r[k], sav_r[k], 0);
      chk($sformatf("gap_X%0d_im", k), got_i[k], sav_i[k], 0);
    end

    // large mixed
    fr = '{476, 452, 54, 732, 43, 457, 543, 900};
    send_frame(0);
    chk("model_mix2_X0", mdl_r[0], 29256, 0);
    wait_done();
    chk("mix2_X0_re", got_r[0], 29256, 0);

    // shifted impulse exercises the W^1/W^3 rounding path
    fr = '{0, 100, 0, 0, 0, 0, 0, 0};
    send_frame(0);
    chk("model_shift_X1_re", mdl_r[1], 566, 0);
    wait_done();
    lit_r = '{800, 566, 0, -566, -800, -566, 0, 566};
    lit_i = '{0, -566, -800, -566, 0, 566, 800, 566};
    chk_lit("shift");

    // complex input
    fr = '{30, -20, 10, 0, -40, 25, 5, -15};
    fi = '{-10, 35, 0, 20, -5, -30, 15, 8};
    send_frame(0);
    wait_done();

    // en held high: samples 8..27 are dropped, next frame is samples 28..35
    for (int t = 0; t <= 56; t++) begin
      @(negedge clk);
      if (t == 8 || t == 36) begin
        for (int n = 0; n < N; n++) begin
          fr[n] = sv_r(t - 8 + n);
          fi[n] = sv_i(t - 8 + n);
        end
        cap_q.push_back(cyc);
        model_frame();
      end
      bus.en     = (t < 56);
      bus.sink_r = DW'(sv_r(t));
      bus.sink_i = DW'(sv_i(t));
    end
    bus.en = 1'b0;
    wait_done();

    // reset during LOAD, then a DC frame must load from address 0
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.en = 1'b1;
      bus.sink_r = DW'(77);
      bus.sink_i = DW'(-33);
    end
    @(negedge clk);
    bus.en = 1'b0;
    pulse_reset("rst_load");
    fr = '{default: 12};
    fi = '{default: 0};
    send_frame(0);
    wait_done();

    // reset during COMPUTE
    fr = '{476, 452, 54, 732, 43, 457, 543, 900};
    send_frame(0);
    repeat (4) @(negedge clk);
    pulse_reset("rst_comp");
    fr = '{12, 49, 2, 48, 70, 13, 5, 6};
    send_frame(0);
    wait_done();
    chk("post_rst_X0_re", got_r[0], 1640, 0);
    chk("post_rst_X4_re", got_r[4], -216, 0);

    // reset during OUTPUT
    send_frame(0);
    begin
      int k;
      k = 0;
      while (!bus.valid && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("rst_out_reached", int'(bus.valid), 1, 0);
    end
    #1;
    pulse_reset("rst_out");
    fr = '{30, -20, 10, 0, -40, 25, 5, -15};
    fi = '{-10, 35, 0, 20, -5, -30, 15, 8};
    send_frame(0);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "watchdog");
  end
endmodule
